// File: rtl/dmem_port_arbiter_if.sv
// Bundle of every handshake/bus signal around the data-memory port arbiter.
// Latency: none (wires only).
// Backpressure: ld_req_ready / st_req_ready are per-cycle grants; a request holds until granted.
//
// Modports:
//   slave  - the arbiter: takes load/store requests, flush and read data;
//            drives grants, memory controls and the load response.
//   master - the surroundings (LSU, store drain, DataMemory) seen as one party.
interface dmem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 6
);
    logic                  ld_req_valid;
    logic                  ld_req_ready;
    logic [ADDR_WIDTH-1:0] ld_req_addr;
    logic [TAG_WIDTH-1:0]  ld_req_tag;
    logic                  st_req_valid;
    logic                  st_req_ready;
    logic [ADDR_WIDTH-1:0] st_req_addr;
    logic [DATA_WIDTH-1:0] st_req_data;
    logic                  flush;
    logic                  mem_write_en;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rdata_valid;
    logic                  ld_resp_valid;
    logic [DATA_WIDTH-1:0] ld_resp_data;
    logic [TAG_WIDTH-1:0]  ld_resp_tag;
    logic                  ld_resp_err;

    modport slave (
        input  ld_req_valid, ld_req_addr, ld_req_tag,
        input  st_req_valid, st_req_addr, st_req_data,
        input  flush, rdata, rdata_valid,
        output ld_req_ready, st_req_ready,
        output mem_write_en, waddr, wdata, mem_rd_en, raddr,
        output ld_resp_valid, ld_resp_data, ld_resp_tag, ld_resp_err
    );

    modport master (
        output ld_req_valid, ld_req_addr, ld_req_tag,
        output st_req_valid, st_req_addr, st_req_data,
        output flush, rdata, rdata_valid,
        input  ld_req_ready, st_req_ready,
        input  mem_write_en, waddr, wdata, mem_rd_en, raddr,
        input  ld_resp_valid, ld_resp_data, ld_resp_tag, ld_resp_err
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the load unit and the committed-store drain.
// Latency: grant and memory controls are combinational; load response 1 cycle after grant.
// Backpressure: one grant per cycle, stores first; a load denied STARVE_LIMIT cycles takes priority.
//
// Ports: clk, rst (async, active low), bus (dmem_port_arbiter_if.slave: load/store requests,
//        flush, DataMemory write/read controls and read data, load response).
// Optional macro DMEM_ARB_STATS_EN adds stat_ld / stat_st / stat_starve (32-bit saturating
// grant counters). Without it the counters and ports are absent and behaviour is identical.
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int TAG_WIDTH    = 6,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    dmem_port_arbiter_if.slave  bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]         stat_ld,
    output logic [31:0]         stat_st,
    output logic [31:0]         stat_starve
`endif
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0]        wait_cnt;
    logic                 inflight_v;
    logic                 inflight_mis;
    logic [TAG_WIDTH-1:0] inflight_tag;

    logic starve;
    logic ld_gnt;
    logic st_gnt;
    logic ld_mis;
    logic st_mis;
    logic resp_v;

    // Grant decision. Gating with rst makes every output read 0 while reset is held.
    always_comb begin
        starve = (wait_cnt >= LIMIT);
        ld_gnt = rst && bus.ld_req_valid && (starve || !bus.st_req_valid) && !bus.flush;
        st_gnt = rst && bus.st_req_valid && !ld_gnt;
        ld_mis = (bus.ld_req_addr[1:0] != 2'b00);
        st_mis = (bus.st_req_addr[1:0] != 2'b00);
        resp_v = rst && inflight_v && !bus.flush;
    end

    always_comb begin
        bus.ld_req_ready  = ld_gnt;
        bus.st_req_ready  = st_gnt;
        bus.mem_rd_en     = 1'b0;
        bus.raddr         = '0;
        bus.mem_write_en  = 1'b0;
        bus.waddr         = '0;
        bus.wdata         = '0;
        if (ld_gnt) begin
            // Misaligned loads are consumed but never reach memory.
            bus.mem_rd_en = !ld_mis;
            bus.raddr     = bus.ld_req_addr;
        end
        if (st_gnt) begin
            // Misaligned stores are consumed and silently dropped.
            bus.mem_write_en = !st_mis;
            bus.waddr        = bus.st_req_addr;
            bus.wdata        = bus.st_req_data;
        end
        bus.ld_resp_valid = resp_v;
        bus.ld_resp_err   = resp_v && inflight_mis;
        bus.ld_resp_tag   = resp_v ? inflight_tag : '0;
        bus.ld_resp_data  = (resp_v && !inflight_mis) ? bus.rdata : '0;
    end

    // Single in-flight slot: memory latency is a fixed cycle, so a new load can be
    // granted every cycle and simply overwrites the slot. A flush blocks the grant,
    // which is what clears the slot for the following cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_v   <= 1'b0;
            inflight_mis <= 1'b0;
            inflight_tag <= '0;
        end else begin
            inflight_v <= ld_gnt;
            if (ld_gnt) begin
                inflight_mis <= ld_mis;
                inflight_tag <= bus.ld_req_tag;
            end
        end
    end

    // Counts consecutive cycles a pending load was denied; saturates at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (ld_gnt || !bus.ld_req_valid) begin
            wait_cnt <= '0;
        end else if (wait_cnt != LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // An aligned load in its response cycle must have data from memory.
    aligned_load_has_data: assert property (
        @(posedge clk) disable iff (!rst)
        (inflight_v && !inflight_mis) |-> bus.rdata_valid
    );

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] ld_grant_cnt;
    logic [31:0] st_grant_cnt;
    logic [31:0] starve_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_grant_cnt <= '0;
            st_grant_cnt <= '0;
            starve_cnt   <= '0;
        end else begin
            if (ld_gnt && (ld_grant_cnt != '1))
                ld_grant_cnt <= ld_grant_cnt + 32'd1;
            if (st_gnt && (st_grant_cnt != '1))
                st_grant_cnt <= st_grant_cnt + 32'd1;
            // Only cycles where the override actually beat a waiting store.
            if (ld_gnt && starve && bus.st_req_valid && (starve_cnt != '1))
                starve_cnt <= starve_cnt + 32'd1;
        end
    end

    assign stat_ld     = ld_grant_cnt;
    assign stat_st     = st_grant_cnt;
    assign stat_starve = starve_cnt;
`endif

endmodule
